speed_controller_multi: RTL and testbench

Parametrised successor to the three-state car speed controller in the Road Fighter game datapath.
- Supports NUM_LEVELS speed levels, a configurable per-shift cooldown, and edge-qualified keypad presses.
- Adds a timed boost mode with recharge, and a crash input that forces a stop.
- Sits between the keypad decoder / one-second tick generator and the road-scroll and score logic, which consume `speed`.

---
 rtl/speed_controller_multi.sv | 170 +++++++++++++++++
 tb/tb_speed_controller_multi.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/speed_controller_multi.sv
// Multi-level car speed controller: edge-qualified gear shifts with cooldown,
// a timed boost with recharge, and a crash input that forces a stop.
module speed_controller_multi #(
    parameter int NUM_LEVELS    = 4,
    parameter int COOLDOWN_SECS = 2,
    parameter int BOOST_SECS    = 3,
    parameter int RECHARGE_SECS = 5,
    parameter int KEY_UP        = 8,
    parameter int KEY_DOWN      = 2,
    parameter int KEY_BOOST     = 5,
    parameter int SPEED_W       = $clog2(NUM_LEVELS)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [3:0]         keypad,
    input  logic               keypad_valid,
    input  logic               one_sec,
    input  logic               crash,
    output logic [SPEED_W-1:0] speed,
    output logic [SPEED_W-1:0] level,
    output logic               boosting,
    output logic               boost_ready,
    output logic               shift_busy
);

    localparam int CD_W   = $clog2(COOLDOWN_SECS + 1);
    localparam int BC_MAX = (BOOST_SECS > RECHARGE_SECS) ? BOOST_SECS : RECHARGE_SECS;
    localparam int BC_W   = $clog2(BC_MAX + 1);

    localparam logic [SPEED_W-1:0] LVL_MAX  = SPEED_W'(NUM_LEVELS - 1);
    localparam logic [SPEED_W-1:0] LVL_ZERO = {SPEED_W{1'b0}};
    localparam logic [SPEED_W-1:0] LVL_ONE  = SPEED_W'(1);
    localparam logic [CD_W-1:0]    CD_INIT  = CD_W'(COOLDOWN_SECS);
    localparam logic [CD_W-1:0]    CD_ZERO  = {CD_W{1'b0}};
    localparam logic [CD_W-1:0]    CD_ONE   = CD_W'(1);
    localparam logic [BC_W-1:0]    BC_BOOST = BC_W'(BOOST_SECS);
    localparam logic [BC_W-1:0]    BC_RECH  = BC_W'(RECHARGE_SECS);
    localparam logic [BC_W-1:0]    BC_ZERO  = {BC_W{1'b0}};
    localparam logic [BC_W-1:0]    BC_ONE   = BC_W'(1);

    typedef enum logic [1:0] {
        B_READY    = 2'b00,
        B_ACTIVE   = 2'b01,
        B_RECHARGE = 2'b10
    } boost_state_e;

    logic                kv_q,    kv_d;
    logic [SPEED_W-1:0]  level_q, level_d;
    logic [SPEED_W-1:0]  speed_q, speed_d;
    logic [CD_W-1:0]     cd_q,    cd_d;
    logic [BC_W-1:0]     bcnt_q,  bcnt_d;
    boost_state_e        bstate_q, bstate_d;

    logic press_s;
    logic key_up_s;
    logic key_down_s;
    logic key_boost_s;

    // Press qualification: a held key yields a single press on its rising edge.
    always_comb begin
        press_s     = keypad_valid & ~kv_q;
        key_up_s    = press_s & (keypad == 4'(KEY_UP));
        key_down_s  = press_s & (keypad == 4'(KEY_DOWN));
        key_boost_s = press_s & (keypad == 4'(KEY_BOOST));
    end

    // Next-state logic: timers first, then one prioritised action per cycle.
    always_comb begin
        kv_d     = keypad_valid;
        level_d  = level_q;
        bstate_d = bstate_q;
        bcnt_d   = bcnt_q;
        if (one_sec && (cd_q != CD_ZERO)) begin
            cd_d = cd_q - CD_ONE;
        end else begin
            cd_d = cd_q;
        end

        case (bstate_q)
            B_READY: begin
                bcnt_d = bcnt_q;
            end
            B_ACTIVE: begin
                if (one_sec) begin
                    if (bcnt_q == BC_ONE) begin
                        bstate_d = B_RECHARGE;
                        bcnt_d   = BC_RECH;
                    end else begin
                        bcnt_d = bcnt_q - BC_ONE;
                    end
                end else begin
                    bcnt_d = bcnt_q;
                end
            end
            B_RECHARGE: begin
                if (one_sec) begin
                    if (bcnt_q == BC_ONE) begin
                        bstate_d = B_READY;
                        bcnt_d   = BC_ZERO;
                    end else begin
                        bcnt_d = bcnt_q - BC_ONE;
                    end
                end else begin
                    bcnt_d = bcnt_q;
                end
            end
            default: begin
                bstate_d = B_READY;
                bcnt_d   = BC_ZERO;
            end
        endcase

        // Crash overrides everything and re-arms the cooldown while held.
        if (crash) begin
            level_d = LVL_ZERO;
            cd_d    = CD_INIT;
            if (bstate_q == B_ACTIVE) begin
                bstate_d = B_RECHARGE;
                bcnt_d   = BC_RECH;
            end else begin
                bstate_d = bstate_d;
            end
        end else if (key_boost_s && (bstate_q == B_READY) && (level_q != LVL_ZERO)) begin
            bstate_d = B_ACTIVE;
            bcnt_d   = BC_BOOST;
        end else if (key_up_s && (cd_q == CD_ZERO) && (level_q < LVL_MAX)
                     && (bstate_q != B_ACTIVE)) begin
            level_d = level_q + LVL_ONE;
            cd_d    = CD_INIT;
        end else if (key_down_s && (cd_q == CD_ZERO) && (level_q != LVL_ZERO)
                     && (bstate_q != B_ACTIVE)) begin
            level_d = level_q - LVL_ONE;
            cd_d    = CD_INIT;
        end else begin
            level_d = level_d;
        end

        if (bstate_d == B_ACTIVE) begin
            speed_d = LVL_MAX;
        end else begin
            speed_d = level_d;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            kv_q     <= 1'b0;
            level_q  <= LVL_ZERO;
            speed_q  <= LVL_ZERO;
            cd_q     <= CD_INIT;
            bstate_q <= B_READY;
            bcnt_q   <= BC_ZERO;
        end else begin
            kv_q     <= kv_d;
            level_q  <= level_d;
            speed_q  <= speed_d;
            cd_q     <= cd_d;
            bstate_q <= bstate_d;
            bcnt_q   <= bcnt_d;
        end
    end

    assign speed       = speed_q;
    assign level       = level_q;
    assign boosting    = (bstate_q == B_ACTIVE);
    assign boost_ready = (bstate_q == B_READY);
    assign shift_busy  = (cd_q != CD_ZERO);

endmodule

// File: tb/tb_speed_controller_multi.sv
// Bench for speed_controller_multi: directed scenarios plus random stimulus,
// every cycle compared against a behavioural model of the controller.
module tb_speed_controller_multi;

    localparam int NL = 4, CDS = 2, BS = 3, RS = 5;
    localparam int KU = 8, KD = 2, KB = 5;
    localparam int MAXL = NL - 1;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [3:0] keypad = 4'd0;
    logic       keypad_valid = 1'b0;
    logic       one_sec = 1'b0;
    logic       crash = 1'b0;
    logic [1:0] speed, level;
    logic       boosting, boost_ready, shift_busy;

    int n_checks = 0;
    int n_fail   = 0;

    // model state: mode 0 = ready, 1 = boosting, 2 = recharging
    int m_level = 0, m_cool = 0, m_mode = 0, m_left = 0;
    bit m_key_held = 0;

    speed_controller_multi #(
        .NUM_LEVELS(NL), .COOLDOWN_SECS(CDS), .BOOST_SECS(BS), .RECHARGE_SECS(RS),
        .KEY_UP(KU), .KEY_DOWN(KD), .KEY_BOOST(KB)
    ) dut (
        .clk(clk), .reset(reset), .keypad(keypad), .keypad_valid(keypad_valid),
        .one_sec(one_sec), .crash(crash), .speed(speed), .level(level),
        .boosting(boosting), .boost_ready(boost_ready), .shift_busy(shift_busy)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_fail++;
            $display("FAIL %s observed=%0d expected=%0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_step(input bit r, input bit v, input int k, input bit t, input bit c);
        bit fresh;
        int cool_next;
        if (r) begin
            m_level = 0; m_cool = CDS; m_mode = 0; m_left = 0; m_key_held = 0;
            return;
        end
        fresh = v && !m_key_held;
        m_key_held = v;
        cool_next = (t && m_cool > 0) ? m_cool - 1 : m_cool;
        if (c) begin
            m_level = 0;
            cool_next = CDS;
            if (m_mode == 1) begin
                m_mode = 2; m_left = RS;
            end else if (m_mode == 2 && t) begin
                m_left--;
                if (m_left == 0) m_mode = 0;
            end
        end else begin
            int mode_before = m_mode;
            if (t && m_mode != 0) begin
                m_left--;
                if (m_left == 0) m_mode = (m_mode == 1) ? 2 : 0;
                if (m_mode == 2 && mode_before == 1) m_left = RS;
            end
            if (fresh && k == KB && mode_before == 0 && m_level > 0) begin
                m_mode = 1; m_left = BS;
            end else if (fresh && k == KU && m_cool == 0 && m_level < MAXL && mode_before != 1) begin
                m_level++; cool_next = CDS;
            end else if (fresh && k == KD && m_cool == 0 && m_level > 0 && mode_before != 1) begin
                m_level--; cool_next = CDS;
            end
        end
        m_cool = cool_next;
    endtask

    task automatic cyc(input bit r, input bit v, input int k, input bit t, input bit c);
        reset = r; keypad_valid = v; keypad = 4'(k); one_sec = t; crash = c;
        @(posedge clk);
        model_step(r, v, k, t, c);
        #1;
        check_eq("level", int'(level), m_level);
        check_eq("speed", int'(speed), (m_mode == 1) ? MAXL : m_level);
        check_eq("boosting", int'(boosting), int'(m_mode == 1));
        check_eq("boost_ready", int'(boost_ready), int'(m_mode == 0));
        check_eq("shift_busy", int'(shift_busy), int'(m_cool != 0));
    endtask

    task automatic press(input int k);
        cyc(0, 1, k, 0, 0);
        cyc(0, 0, 0, 0, 0);
    endtask

    task automatic tick();
        cyc(0, 0, 0, 1, 0);
    endtask

    initial begin
        bit v;
        int k;
        // reset state
        cyc(1, 0, 0, 0, 0);
        check_eq("rst_level", int'(level), 0);
        check_eq("rst_busy", int'(shift_busy), 1);
        check_eq("rst_ready", int'(boost_ready), 1);
        tick();
        check_eq("busy_after_1tick", int'(shift_busy), 1);
        tick();
        check_eq("busy_after_2tick", int'(shift_busy), 0);
        cyc(0, 1, KU, 0, 0);
        check_eq("first_up_level", int'(level), 1);
        check_eq("first_up_busy", int'(shift_busy), 1);
        cyc(0, 0, 0, 0, 0);

        // presses during cooldown are dropped; a held key makes one press
        for (int i = 0; i < 3; i++) press(KU);
        check_eq("busy_drop_level", int'(level), 1);
        cyc(0, 1, KU, 0, 0);
        cyc(0, 1, KU, 1, 0);
        cyc(0, 1, KU, 1, 0);
        cyc(0, 1, KU, 0, 0);
        check_eq("held_key_level", int'(level), 1);
        cyc(0, 0, 0, 0, 0);

        // climb to max, saturate, then shift down
        press(KU);
        tick(); tick();
        press(KU);
        check_eq("climb_level", int'(level), 3);
        tick(); tick();
        press(KU);
        check_eq("max_hold_level", int'(level), 3);
        check_eq("max_no_reload", int'(shift_busy), 0);
        press(KD);
        check_eq("down_level", int'(level), 2);
        tick(); tick();
        press(KD);
        tick(); tick();

        // boost at level 1
        press(KB);
        check_eq("boost_on", int'(boosting), 1);
        check_eq("boost_speed", int'(speed), 3);
        check_eq("boost_level", int'(level), 1);
        press(KU);
        check_eq("boost_up_ignored", int'(level), 1);
        tick(); tick(); tick();
        check_eq("boost_off", int'(boosting), 0);
        check_eq("boost_off_speed", int'(speed), 1);
        check_eq("recharging", int'(boost_ready), 0);
        for (int i = 0; i < 4; i++) tick();
        check_eq("still_recharging", int'(boost_ready), 0);
        tick();
        check_eq("recharged", int'(boost_ready), 1);

        // crash while boosting at level 2
        press(KU);
        press(KB);
        check_eq("boost2_speed", int'(speed), 3);
        cyc(0, 0, 0, 0, 1);
        check_eq("crash_level", int'(level), 0);
        check_eq("crash_speed", int'(speed), 0);
        check_eq("crash_boost", int'(boosting), 0);
        check_eq("crash_busy", int'(shift_busy), 1);
        check_eq("crash_recharge", int'(boost_ready), 0);
        press(KU);
        check_eq("crash_up_ignored", int'(level), 0);
        tick(); tick();
        press(KU);
        tick(); tick(); tick();

        // reset mid-boost, mid-cooldown, with tick and press in the same cycle
        press(KU);
        press(KB);
        check_eq("pre_reset_boost", int'(boosting), 1);
        cyc(1, 1, KU, 1, 0);
        check_eq("rst2_level", int'(level), 0);
        check_eq("rst2_speed", int'(speed), 0);
        check_eq("rst2_boost", int'(boosting), 0);
        check_eq("rst2_ready", int'(boost_ready), 1);
        check_eq("rst2_busy", int'(shift_busy), 1);
        cyc(0, 0, 0, 0, 0);

        // random phase
        v = 0;
        for (int i = 0; i < 5000; i++) begin
            if ($urandom_range(0, 2) == 0) v = ~v;
            case ($urandom_range(0, 3))
                0: k = KU;
                1: k = KD;
                2: k = KB;
                default: k = $urandom_range(0, 15);
            endcase
            cyc(($urandom_range(0, 499) == 0), v, k,
                ($urandom_range(0, 5) == 0), ($urandom_range(0, 59) == 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
